// File: rtl/mem_port_arb.sv
// mem_port_arb: shares one single-port memory bus between instruction fetch
// and the load/store unit. There is at most one outstanding transaction. The
// LSU has priority, and a starvation counter hands the bus to fetch after
// STARVE_MAX consecutive LSU wins. Responses pass straight through to the
// requester that owns the transaction.
module mem_port_arb #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_adr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [XLEN-1:0] if_rdata_o,
  input  logic            lsu_req_i,
  input  logic [XLEN-1:0] lsu_adr_i,
  input  logic            lsu_is_store_i,
  input  logic [XLEN-1:0] lsu_store_data_i,
  input  logic [2:0]      lsu_access_size_i,
  output logic            lsu_gnt_o,
  output logic            lsu_rvalid_o,
  output logic [XLEN-1:0] lsu_rdata_o,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_adr_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [2:0]      mem_size_o,
  input  logic            mem_ready_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            stall_if_o,
  output logic            stall_exe_o,
  output logic            err_o
);

  localparam int unsigned   CW         = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_IF  = 2'd1,
    WAIT_LSU = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   starve_cnt_q, starve_cnt_d;
  logic            err_q, err_d;

  logic if_resp, lsu_resp, if_elig, lsu_elig, slot_open;
  logic if_win, lsu_win, accept;

  // State, starvation counter and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      err_q        <= err_d;
    end
  end

  // Arbitration, next state and all outputs; outputs are held low in reset.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    err_d        = err_q;
    if_gnt_o     = 1'b0;
    if_rvalid_o  = 1'b0;
    if_rdata_o   = '0;
    lsu_gnt_o    = 1'b0;
    lsu_rvalid_o = 1'b0;
    lsu_rdata_o  = '0;
    mem_req_o    = 1'b0;
    mem_adr_o    = '0;
    mem_we_o     = 1'b0;
    mem_wdata_o  = '0;
    mem_size_o   = 3'b000;
    stall_if_o   = 1'b0;
    stall_exe_o  = 1'b0;
    err_o        = 1'b0;

    if_resp   = (state_q == WAIT_IF)  && mem_rvalid_i;
    lsu_resp  = (state_q == WAIT_LSU) && mem_rvalid_i;
    // The owner of the in-flight transaction still holds its old request,
    // including in its response cycle, so it cannot compete for the slot.
    if_elig   = if_req_i  && (state_q != WAIT_IF);
    lsu_elig  = lsu_req_i && (state_q != WAIT_LSU);
    slot_open = (state_q == IDLE) || if_resp || lsu_resp;

    if_win  = slot_open && if_elig && (!lsu_elig || (starve_cnt_q == STARVE_LIM));
    lsu_win = slot_open && lsu_elig && !if_win;
    accept  = (if_win || lsu_win) && mem_ready_i;

    if (accept) begin
      state_d = if_win ? WAIT_IF : WAIT_LSU;
    end else if (if_resp || lsu_resp) begin
      state_d = IDLE;
    end

    if (accept && if_win) begin
      starve_cnt_d = '0;
    end else if (accept && if_elig && (starve_cnt_q != STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end

    if ((state_q == IDLE) && mem_rvalid_i) begin
      err_d = 1'b1;
    end

    if (!reset) begin
      mem_req_o = if_win || lsu_win;
      if (lsu_win) begin
        mem_adr_o   = lsu_adr_i;
        mem_we_o    = lsu_is_store_i;
        mem_wdata_o = lsu_store_data_i;
        mem_size_o  = lsu_access_size_i;
      end else if (if_win) begin
        mem_adr_o  = if_adr_i;
        mem_size_o = 3'b010;
      end
      if_gnt_o     = accept && if_win;
      lsu_gnt_o    = accept && lsu_win;
      if_rvalid_o  = if_resp;
      lsu_rvalid_o = lsu_resp;
      if_rdata_o   = if_resp  ? mem_rdata_i : '0;
      lsu_rdata_o  = lsu_resp ? mem_rdata_i : '0;
      stall_if_o   = if_req_i  && !if_resp;
      stall_exe_o  = lsu_req_i && !lsu_resp;
      err_o        = err_q;
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: random requesters and a variable-latency memory drive the
// arbiter; a transaction-level reference model predicts every output.
module tb_mem_port_arb;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned STARVE_MAX = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            if_req_i;
  logic [XLEN-1:0] if_adr_i;
  logic            if_gnt_o, if_rvalid_o;
  logic [XLEN-1:0] if_rdata_o;
  logic            lsu_req_i;
  logic [XLEN-1:0] lsu_adr_i;
  logic            lsu_is_store_i;
  logic [XLEN-1:0] lsu_store_data_i;
  logic [2:0]      lsu_access_size_i;
  logic            lsu_gnt_o, lsu_rvalid_o;
  logic [XLEN-1:0] lsu_rdata_o;
  logic            mem_req_o, mem_we_o;
  logic [XLEN-1:0] mem_adr_o, mem_wdata_o;
  logic [2:0]      mem_size_o;
  logic            mem_ready_i, mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;
  logic            stall_if_o, stall_exe_o, err_o;

  mem_port_arb #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .if_req_i(if_req_i), .if_adr_i(if_adr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_adr_i(lsu_adr_i), .lsu_is_store_i(lsu_is_store_i),
    .lsu_store_data_i(lsu_store_data_i), .lsu_access_size_i(lsu_access_size_i),
    .lsu_gnt_o(lsu_gnt_o), .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .mem_req_o(mem_req_o), .mem_adr_o(mem_adr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o),
    .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .stall_if_o(stall_if_o), .stall_exe_o(stall_exe_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  int unsigned cyc     = 0;

  // Reference model: who owns the outstanding transaction (0 none, 1 IF,
  // 2 LSU), how many LSU wins in a row fetch has watched, sticky error.
  int unsigned m_owner  = 0;
  int unsigned m_streak = 0;
  bit          m_err    = 1'b0;
  // Memory model: one pending response, delivered when mb_lat reaches 1.
  bit          mb_busy  = 1'b0;
  int unsigned mb_lat   = 0;
  // Requester bookkeeping: a response was delivered, drop req next cycle.
  bit          if_done  = 1'b0;
  bit          lsu_done = 1'b0;
  int unsigned p_if = 50, p_lsu = 50, p_rdy = 70;

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic cycle(input bit do_rst, input bit spur);
    int unsigned     win;
    int unsigned     resp_to;
    bit              if_el, lsu_el, open, acc;
    logic            e_req, e_we, e_ig, e_lg, e_irv, e_lrv, e_sif, e_sex, e_err;
    logic [XLEN-1:0] e_adr, e_wd;
    logic [2:0]      e_sz;

    @(posedge clk);
    #1;
    cyc++;
    reset = do_rst;
    if (if_done  || do_rst) if_req_i  = 1'b0;
    if (lsu_done || do_rst) lsu_req_i = 1'b0;
    if_done  = 1'b0;
    lsu_done = 1'b0;
    if (!do_rst && !if_req_i && ($urandom_range(0, 99) < p_if)) begin
      if_req_i = 1'b1;
      if_adr_i = $urandom & 32'hFFFF_FFFC;
    end
    if (!do_rst && !lsu_req_i && ($urandom_range(0, 99) < p_lsu)) begin
      lsu_req_i         = 1'b1;
      lsu_adr_i         = $urandom;
      lsu_is_store_i    = 1'($urandom_range(0, 1));
      lsu_store_data_i  = $urandom;
      lsu_access_size_i = 3'($urandom_range(0, 7));
    end
    mem_ready_i  = ($urandom_range(0, 99) < p_rdy);
    mem_rvalid_i = !do_rst && (spur || (mb_busy && (mb_lat == 1)));
    mem_rdata_i  = $urandom;

    @(negedge clk);
    e_req = 0; e_we = 0; e_ig = 0; e_lg = 0; e_irv = 0; e_lrv = 0;
    e_sif = 0; e_sex = 0; e_err = 0; e_adr = '0; e_wd = '0; e_sz = '0;
    win = 0; resp_to = 0; acc = 0; if_el = 0;

    if (!do_rst) begin
      resp_to = mem_rvalid_i ? m_owner : 0;
      if_el   = if_req_i  && (m_owner != 1);
      lsu_el  = lsu_req_i && (m_owner != 2);
      open    = (m_owner == 0) || (resp_to != 0);
      if (open) begin
        if (if_el && (!lsu_el || (m_streak >= STARVE_MAX))) win = 1;
        else if (lsu_el) win = 2;
      end
      e_req = (win != 0);
      acc   = e_req && mem_ready_i;
      if (win == 2) begin
        e_adr = lsu_adr_i; e_we = lsu_is_store_i; e_wd = lsu_store_data_i; e_sz = lsu_access_size_i;
      end else if (win == 1) begin
        e_adr = if_adr_i; e_sz = 3'b010;
      end
      e_ig  = acc && (win == 1);
      e_lg  = acc && (win == 2);
      e_irv = (resp_to == 1);
      e_lrv = (resp_to == 2);
      e_sif = if_req_i  && !e_irv;
      e_sex = lsu_req_i && !e_lrv;
      e_err = m_err;
    end

    chk("mem_req", 32'(mem_req_o), 32'(e_req));
    chk("mem_adr", mem_adr_o, e_adr);
    chk("mem_we", 32'(mem_we_o), 32'(e_we));
    chk("mem_wdata", mem_wdata_o, e_wd);
    chk("mem_size", 32'(mem_size_o), 32'(e_sz));
    chk("if_gnt", 32'(if_gnt_o), 32'(e_ig));
    chk("lsu_gnt", 32'(lsu_gnt_o), 32'(e_lg));
    chk("if_rvalid", 32'(if_rvalid_o), 32'(e_irv));
    chk("lsu_rvalid", 32'(lsu_rvalid_o), 32'(e_lrv));
    chk("stall_if", 32'(stall_if_o), 32'(e_sif));
    chk("stall_exe", 32'(stall_exe_o), 32'(e_sex));
    chk("err", 32'(err_o), 32'(e_err));
    if (do_rst) begin
      chk("if_rdata_rst", if_rdata_o, '0);
      chk("lsu_rdata_rst", lsu_rdata_o, '0);
    end
    if (e_irv) chk("if_rdata", if_rdata_o, mem_rdata_i);
    if (e_lrv) chk("lsu_rdata", lsu_rdata_o, mem_rdata_i);

    if (do_rst) begin
      m_owner = 0; m_streak = 0; m_err = 1'b0; mb_busy = 1'b0;
    end else begin
      if (mem_rvalid_i && (m_owner == 0)) m_err = 1'b1;
      if (acc) m_owner = win;
      else if (resp_to != 0) m_owner = 0;
      if (acc && (win == 1)) m_streak = 0;
      else if (acc && if_el && (m_streak < STARVE_MAX)) m_streak++;
      if (mem_rvalid_i && !spur) mb_busy = 1'b0;
      else if (mb_busy) mb_lat--;
      if (acc) begin
        mb_busy = 1'b1;
        mb_lat  = $urandom_range(1, 3);
      end
      if_done  = e_irv;
      lsu_done = e_lrv;
    end
  endtask

  int unsigned ph_if  [4] = '{60, 100, 30, 100};
  int unsigned ph_lsu [4] = '{60, 100, 90, 100};
  int unsigned ph_rdy [4] = '{70, 50,  40, 100};

  initial begin
    reset = 1'b1; if_req_i = 0; if_adr_i = '0; lsu_req_i = 0; lsu_adr_i = '0;
    lsu_is_store_i = 0; lsu_store_data_i = '0; lsu_access_size_i = '0;
    mem_ready_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;

    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    for (int ph = 0; ph < 4; ph++) begin
      p_if = ph_if[ph]; p_lsu = ph_lsu[ph]; p_rdy = ph_rdy[ph];
      for (int i = 0; i < 800; i++) begin
        cycle($urandom_range(0, 149) == 0, 1'b0);
      end
    end

    // Drain to idle, then inject an unsolicited response.
    p_if = 0; p_lsu = 0; p_rdy = 100;
    for (int i = 0; i < 20; i++) begin
      if ((m_owner == 0) && !mb_busy && !if_req_i && !lsu_req_i) break;
      cycle(1'b0, 1'b0);
    end
    if ((m_owner == 0) && !mb_busy) cycle(1'b0, 1'b1);
    else chk("drain_timeout", 32'(m_owner), 32'd0);
    p_if = 60; p_lsu = 60; p_rdy = 70;
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
